bcd_regfile_it: RTL and testbench



---
 rtl/bcd_regfile_it.sv | 113 +++++++++++
 tb/tb_bcd_regfile_it.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_regfile_it.sv
// bcd_regfile_it: DEPTH-channel value store with a shared iterative double-dabble BCD converter.
// A get latches the channel value and shifts it into the BCD accumulator one bit per enabled cycle.
module bcd_regfile_it #(
    parameter int DATA_W = 16,
    parameter int DEPTH = 4,
    parameter int DIGITS = 6,
    parameter int SIGNED = 0,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int BCD_W = 4 * DIGITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              set_i,
    input  logic              get_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic [BCD_W-1:0]  bcd_digits_o,
    output logic              sign_o,
    output logic              valid_o,
    output logic              bcd_cvt_busy_o,
    output logic              err_o
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    function automatic bit digits_fit();
        logic [127:0] p;
        p = 128'd1;
        for (int i = 0; i < DIGITS; i++) p = p * 128'd10;
        return p > (128'd1 << DATA_W);
    endfunction

    if (!digits_fit()) begin : g_fit
        $error("bcd_regfile_it: DIGITS too small for DATA_W");
    end

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  regs_q [DEPTH];
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  sh_q, sh_d, data_q, val, mag;
    logic [BCD_W-1:0]   acc_q, acc_d, adj, bcd_q;
    logic               sign_lat_q, sign_q, valid_q, err_q;
    logic               addr_ok, get_ok, neg, err;

    assign addr_ok = int'(addr_i) < DEPTH;
    assign get_ok = en && get_i && addr_ok && state_q == IDLE;
    // Same-cycle set to the same channel bypasses the register file.
    assign val = set_i ? data_i : regs_q[addr_i];
    assign neg = SIGNED != 0 && val[DATA_W-1];
    assign mag = neg ? -val : val;
    assign err = en && ((get_i && (state_q == SHIFT || !addr_ok)) || (set_i && !addr_ok));

    always_comb begin
        adj = acc_q;
        for (int i = 0; i < DIGITS; i++)
            if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        {acc_d, sh_d} = {adj, sh_q} << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q     <= '{default: '0};
            state_q    <= IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            acc_q      <= '0;
            sign_lat_q <= 1'b0;
            data_q     <= '0;
            bcd_q      <= '0;
            sign_q     <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= err;
            if (en && set_i && addr_ok) regs_q[addr_i] <= data_i;
            if (en) begin
                case (state_q)
                    IDLE: if (get_ok) begin
                        data_q     <= val;
                        sh_q       <= mag;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        sign_lat_q <= neg;
                        state_q    <= SHIFT;
                    end
                    SHIFT: begin
                        acc_q <= acc_d;
                        sh_q  <= sh_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            bcd_q   <= acc_d;
                            sign_q  <= sign_lat_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign data_o         = data_q;
    assign bcd_digits_o   = bcd_q;
    assign sign_o         = sign_q;
    assign valid_o        = valid_q;
    assign bcd_cvt_busy_o = state_q == SHIFT;
    assign err_o          = err_q;
endmodule

// File: tb/tb_bcd_regfile_it.sv
// tb_bcd_regfile_it: directed checks of an unsigned DEPTH=4 instance and a signed DEPTH=3 instance
// driven by the same stimulus.
module tb_bcd_regfile_it;
    logic        clk = 1'b0, rst = 1'b1, en = 1'b1, set_i = 1'b0, get_i = 1'b0;
    logic [1:0]  addr = '0;
    logic [15:0] data = '0;
    logic [15:0] u_data, s_data;
    logic [23:0] u_bcd, s_bcd;
    logic        u_sign, u_valid, u_busy, u_err, s_sign, s_valid, s_busy, s_err;
    int          tests = 0, fails = 0, n, cnt;

    always #5 clk = ~clk;

    bcd_regfile_it dut_u (
        .clk(clk), .rst(rst), .en(en), .set_i(set_i), .get_i(get_i), .addr_i(addr),
        .data_i(data), .data_o(u_data), .bcd_digits_o(u_bcd), .sign_o(u_sign),
        .valid_o(u_valid), .bcd_cvt_busy_o(u_busy), .err_o(u_err)
    );

    bcd_regfile_it #(.DEPTH(3), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .en(en), .set_i(set_i), .get_i(get_i), .addr_i(addr),
        .data_i(data), .data_o(s_data), .bcd_digits_o(s_bcd), .sign_o(s_sign),
        .valid_o(s_valid), .bcd_cvt_busy_o(s_busy), .err_o(s_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_set(input logic [1:0] a, input logic [15:0] d);
        set_i = 1'b1; addr = a; data = d;
        step();
        set_i = 1'b0;
    endtask

    task automatic do_get(input logic [1:0] a);
        get_i = 1'b1; addr = a;
        step();
        get_i = 1'b0;
    endtask

    task automatic wait_valid(output int c);
        c = 0;
        while (!u_valid && c < 100) begin
            step();
            c++;
        end
    endtask

    initial begin
        step(); step();
        rst = 1'b0;
        chk("rst_data", u_data, 0);
        chk("rst_bcd", u_bcd, 0);
        chk("rst_valid", u_valid, 0);
        chk("rst_busy", u_busy, 0);
        chk("rst_err", u_err, 0);
        chk("rst_sign_s", s_sign, 0);

        do_set(0, 16'd65233);
        do_get(0);
        chk("get_data", u_data, 65233);
        chk("get_busy", u_busy, 1);
        wait_valid(n);
        chk("lat_65233", n, 16);
        chk("bcd_65233", u_bcd, 24'h065233);
        chk("busy_fall", u_busy, 0);
        chk("sign_u0", u_sign, 0);
        chk("bcd_s_m303", s_bcd, 24'h000303);
        chk("sign_s_m303", s_sign, 1);
        step();
        chk("valid_once", u_valid, 0);

        do_set(1, 16'd65535);
        do_get(1);
        wait_valid(n);
        chk("bcd_65535", u_bcd, 24'h065535);
        chk("bcd_s_m1", s_bcd, 24'h000001);
        do_set(2, 16'd0);
        do_get(2);
        chk("busy_zero", u_busy, 1);
        wait_valid(n);
        chk("lat_zero", n, 16);
        chk("bcd_zero", u_bcd, 24'h000000);
        chk("sign_s_zero", s_sign, 0);

        do_set(0, 16'hFB2E);
        do_get(0);
        wait_valid(n);
        chk("bcd_s_m1234", s_bcd, 24'h001234);
        chk("sign_s_m1234", s_sign, 1);
        chk("bcd_u_64302", u_bcd, 24'h064302);
        do_set(0, 16'h8000);
        do_get(0);
        wait_valid(n);
        chk("bcd_s_min", s_bcd, 24'h032768);
        chk("sign_s_min", s_sign, 1);
        chk("bcd_u_32768", u_bcd, 24'h032768);
        chk("sign_u_32768", u_sign, 0);
        do_set(0, 16'd1234);
        do_get(0);
        wait_valid(n);
        chk("bcd_s_p1234", s_bcd, 24'h001234);
        chk("sign_s_p1234", s_sign, 0);

        do_set(0, 16'd500);
        do_get(0);
        step(); step(); step();
        set_i = 1'b1; get_i = 1'b1; addr = 0; data = 16'd7;
        step();
        set_i = 1'b0; get_i = 1'b0;
        chk("err_busy_get", u_err, 1);
        step();
        chk("err_pulse_once", u_err, 0);
        wait_valid(n);
        chk("lat_after_rej", n, 11);
        chk("bcd_old_500", u_bcd, 24'h000500);
        do_get(0);
        chk("data_new_7", u_data, 7);
        wait_valid(n);
        chk("bcd_new_7", u_bcd, 24'h000007);

        set_i = 1'b1; get_i = 1'b1; addr = 3; data = 16'd42;
        step();
        set_i = 1'b0; get_i = 1'b0;
        chk("bypass_data", u_data, 42);
        chk("bypass_err_u", u_err, 0);
        chk("depth3_err_s", s_err, 1);
        chk("depth3_busy_s", s_busy, 0);
        wait_valid(n);
        chk("bypass_bcd", u_bcd, 24'h000042);
        do_set(3, 16'd999);
        chk("depth3_set_err", s_err, 1);
        chk("set3_err_u", u_err, 0);
        do_get(0);
        chk("depth3_ch0_kept", s_data, 7);
        wait_valid(n);

        do_get(1);
        for (int i = 0; i < 8; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_data", u_data, 0);
        chk("abort_bcd", u_bcd, 0);
        chk("abort_busy", u_busy, 0);
        chk("abort_sign_s", s_sign, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cnt += int'(u_valid);
        end
        chk("abort_no_valid", cnt, 0);
        do_set(1, 16'd9876);
        do_get(1);
        wait_valid(n);
        chk("post_rst_lat", n, 16);
        chk("post_rst_bcd", u_bcd, 24'h009876);

        do_get(1);
        for (int i = 0; i < 5; i++) step();
        en = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("en0_busy", u_busy, 1);
        chk("en0_valid", u_valid, 0);
        en = 1'b1;
        wait_valid(n);
        chk("en0_lat", n, 11);
        chk("en0_bcd", u_bcd, 24'h009876);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
